// File: rtl/seqdet_pkg.sv
// Shared types and legal parameter ranges for the serial pattern detector.
package seqdet_pkg;

    typedef enum logic [0:0] {
        StFill,
        StHunt
    } seqdet_state_e;

    localparam int unsigned PAT_W_MIN = 2;
    localparam int unsigned PAT_W_MAX = 16;
    localparam int unsigned CNT_W_MIN = 1;
    localparam int unsigned CNT_W_MAX = 32;

    // Fill counter must represent 0..pat_w inclusive.
    function automatic int unsigned fill_width(int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seqdet_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seqdet_sat_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector with overlap control.
// Define SEQDET_CNT_EN to build in the saturating match counter and cnt_clr.
module seq_detect_param
    import seqdet_pkg::*;
#(
    parameter int unsigned      PAT_W     = 3,
    parameter int unsigned      CNT_W     = 8,
    parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(3'b101),
    parameter bit               RESET_OVL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned FILL_W = fill_width(PAT_W);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : gen_bad_pat_w
        $error("seq_detect_param: PAT_W out of legal range");
    end
    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : gen_bad_cnt_w
        $error("seq_detect_param: CNT_W out of legal range");
    end

    seqdet_state_e    state_q;
    logic [FILL_W-1:0] fill_q;
    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] pat_q;
    logic             ovl_q;
    logic             out_q;

    logic [PAT_W-1:0] hist_shift;
    logic             full_next;
    logic             match;

    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], in};
        // Window is full after this bit if already hunting or this bit completes the fill.
        full_next  = (state_q == StHunt) || (fill_q == FILL_W'(PAT_W - 1));
        match      = in_valid && !cfg_load && full_next && (hist_shift == pat_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFill;
            fill_q  <= '0;
            hist_q  <= '0;
            pat_q   <= RESET_PAT;
            ovl_q   <= RESET_OVL;
            out_q   <= 1'b0;
        end else if (cfg_load) begin
            state_q <= StFill;
            fill_q  <= '0;
            hist_q  <= '0;
            pat_q   <= pattern;
            ovl_q   <= overlap;
            out_q   <= 1'b0;
        end else begin
            out_q <= match;
            if (in_valid) begin
                hist_q <= hist_shift;
                if (match && !ovl_q) begin
                    state_q <= StFill;
                    fill_q  <= '0;
                end else if (full_next) begin
                    state_q <= StHunt;
                    fill_q  <= FILL_W'(PAT_W);
                end else begin
                    state_q <= StFill;
                    fill_q  <= fill_q + 1'b1;
                end
            end
        end
    end

    assign out = out_q;

`ifdef SEQDET_CNT_EN
    seqdet_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_sat_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (match),
        .clr  (cnt_clr),
        .cnt  (match_cnt)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench: directed vector table, corner-case sequences and random stimulus.
module tb_seq_detect_param;

`ifdef SEQDET_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       in_valid;
    logic       cfg_load;
    logic [2:0] pattern;
    logic       overlap;
    logic       cnt_clr;
    logic       out8;
    logic       out2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    seq_detect_param dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (din),
        .in_valid (in_valid),
        .cfg_load (cfg_load),
        .pattern  (pattern),
        .overlap  (overlap),
        .cnt_clr  (cnt_clr),
        .out      (out8),
        .match_cnt(cnt8)
    );

    seq_detect_param #(
        .CNT_W(2)
    ) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (din),
        .in_valid (in_valid),
        .cfg_load (cfg_load),
        .pattern  (pattern),
        .overlap  (overlap),
        .cnt_clr  (cnt_clr),
        .out      (out2),
        .match_cnt(cnt2)
    );

    int n_run  = 0;
    int n_fail = 0;

    // Reference model: the bits seen since detection last (re)started, newest at the back.
    bit       m_win[$];
    bit [2:0] m_pat;
    bit       m_ovl;
    int       m_cnt8;
    int       m_cnt2;
    bit       m_out;

    typedef struct {
        bit       v;
        bit       b;
        bit       cfg;
        bit [2:0] pat;
        bit       ovl;
        bit       exp_out;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_win.delete();
        m_pat  = 3'b101;
        m_ovl  = 1'b1;
        m_cnt8 = 0;
        m_cnt2 = 0;
        m_out  = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit cfg, input bit [2:0] pat,
                              input bit ovl, input bit clr);
        bit hit;
        hit = 1'b0;
        if (cfg) begin
            m_pat = pat;
            m_ovl = ovl;
            m_win.delete();
        end else if (v) begin
            m_win.push_back(b);
            if (m_win.size() > 3) m_win = m_win[1:$];
            if (m_win.size() == 3 && {m_win[0], m_win[1], m_win[2]} == m_pat) begin
                hit = 1'b1;
                if (!m_ovl) m_win.delete();
            end
        end
        m_out = hit;
        if (clr) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (hit) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic cycle(input bit v, input bit b, input bit cfg, input bit [2:0] pat,
                         input bit ovl, input bit clr, input string tag);
        in_valid = v;
        din      = b;
        cfg_load = cfg;
        pattern  = pat;
        overlap  = ovl;
        cnt_clr  = clr;
        model_step(v, b, cfg, pat, ovl, clr);
        @(posedge clk);
        #1;
        check($sformatf("%s.out8", tag), 32'(out8), 32'(m_out));
        check($sformatf("%s.out2", tag), 32'(out2), 32'(m_out));
        check($sformatf("%s.cnt8", tag), 32'(cnt8), CNT_EN ? m_cnt8 : 0);
        check($sformatf("%s.cnt2", tag), 32'(cnt2), CNT_EN ? m_cnt2 : 0);
    endtask

    task automatic bit_in(input bit b, input string tag);
        cycle(1'b1, b, 1'b0, 3'b000, 1'b0, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #2;
        check($sformatf("%s.rst_out8", tag), 32'(out8), 0);
        check($sformatf("%s.rst_out2", tag), 32'(out2), 0);
        check($sformatf("%s.rst_cnt8", tag), 32'(cnt8), 0);
        check($sformatf("%s.rst_cnt2", tag), 32'(cnt2), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t tbl[$];
        int   exp2[5];
        int   k;

        rst_n    = 1'b0;
        din      = 1'b0;
        in_valid = 1'b0;
        cfg_load = 1'b0;
        pattern  = 3'b000;
        overlap  = 1'b0;
        cnt_clr  = 1'b0;
        model_reset();
        do_reset("reset");

        // Default pattern 101, overlapping: pulses after bits 3 and 5.
        tbl.push_back('{1, 1, 0, 3'b000, 0, 0});
        tbl.push_back('{1, 0, 0, 3'b000, 0, 0});
        tbl.push_back('{1, 1, 0, 3'b000, 0, 1});
        tbl.push_back('{1, 0, 0, 3'b000, 0, 0});
        tbl.push_back('{1, 1, 0, 3'b000, 0, 1});
        // Non-overlapping 101: pulse after bit 3 only.
        tbl.push_back('{0, 0, 1, 3'b101, 0, 0});
        tbl.push_back('{1, 1, 0, 3'b000, 0, 0});
        tbl.push_back('{1, 0, 0, 3'b000, 0, 0});
        tbl.push_back('{1, 1, 0, 3'b000, 0, 1});
        tbl.push_back('{1, 0, 0, 3'b000, 0, 0});
        tbl.push_back('{1, 1, 0, 3'b000, 0, 0});
        // 1,0, four invalid cycles with noise on in, then 1: single pulse.
        tbl.push_back('{0, 0, 1, 3'b101, 1, 0});
        tbl.push_back('{1, 1, 0, 3'b000, 0, 0});
        tbl.push_back('{1, 0, 0, 3'b000, 0, 0});
        tbl.push_back('{0, 1, 0, 3'b000, 0, 0});
        tbl.push_back('{0, 1, 0, 3'b000, 0, 0});
        tbl.push_back('{0, 0, 0, 3'b000, 0, 0});
        tbl.push_back('{0, 1, 0, 3'b000, 0, 0});
        tbl.push_back('{1, 1, 0, 3'b000, 0, 1});
        tbl.push_back('{0, 0, 0, 3'b000, 0, 0});

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].b, tbl[i].cfg, tbl[i].pat, tbl[i].ovl, 1'b0,
                  $sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_out", i), 32'(out8), 32'(tbl[i].exp_out));
        end
        check("table.total_cnt8", 32'(cnt8), CNT_EN ? 4 : 0);

        // Saturation of a 2-bit counter, then clear coinciding with a match.
        do_reset("sat");
        exp2 = '{1, 2, 3, 3, 3};
        k = 0;
        for (int i = 0; i < 11; i++) begin
            bit_in(i % 2 == 0, $sformatf("sat%0d", i));
            if (i >= 2 && i % 2 == 0) begin
                check($sformatf("sat%0d.cnt2_fixed", i), 32'(cnt2), CNT_EN ? exp2[k] : 0);
                k++;
            end
        end
        bit_in(1'b0, "sat_b0");
        cycle(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, "sat_clr");
        check("sat_clr.out_fixed", 32'(out8), 1);
        check("sat_clr.cnt2_fixed", 32'(cnt2), 0);

        // Reset mid-pattern, then cfg_load coinciding with a valid bit.
        do_reset("mid");
        bit_in(1'b1, "mid_b1");
        bit_in(1'b0, "mid_b0");
        do_reset("mid2");
        bit_in(1'b1, "post_rst");
        check("post_rst.out_fixed", 32'(out8), 0);
        bit_in(1'b0, "pre_cfg");
        cycle(1'b1, 1'b1, 1'b1, 3'b101, 1'b1, 1'b0, "cfg_valid");
        check("cfg_valid.out_fixed", 32'(out8), 0);
        bit_in(1'b1, "cfg_f1");
        check("cfg_f1.out_fixed", 32'(out8), 0);
        bit_in(1'b0, "cfg_f2");
        check("cfg_f2.out_fixed", 32'(out8), 0);
        bit_in(1'b1, "cfg_f3");
        check("cfg_f3.out_fixed", 32'(out8), 1);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 3) begin
                do_reset($sformatf("rnd%0d", i));
            end else begin
                cycle($urandom_range(0, 3) != 0, 1'($urandom), r < 25, 3'($urandom),
                      1'($urandom), $urandom_range(0, 31) == 0, $sformatf("rnd%0d", i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_W, default 3, meaning pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-003 SHALL have parameter RESET_PAT, default 3'b101 (PAT_W bits), meaning the pattern active after reset.
REQ-004 SHALL have parameter RESET_OVL, default 1, meaning the overlap mode active after reset.
REQ-005 SHALL have port clk, input, 1, the single clock, with all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-007 SHALL have port in, input, 1, the serial data bit.
REQ-008 SHALL have port in_valid, input, 1, qualifying in; bits are sampled only when high.
REQ-009 SHALL have port cfg_load, input, 1, a strobe that latches pattern and overlap.
REQ-010 SHALL have port pattern, input, PAT_W, the new pattern; bit PAT_W-1 is the oldest bit.
REQ-011 SHALL have port overlap, input, 1, the new mode: 1 = overlapping, 0 = non-overlapping.
REQ-012 SHALL have port cnt_clr, input, 1, a synchronous clear of match_cnt.
REQ-013 SHALL have port out, output, 1, a registered one-cycle match pulse.
REQ-014 SHALL have port match_cnt, output, CNT_W, a saturating count of matches.

Function
REQ-015 SHALL shift each valid bit into history at the LSB, with the oldest bit at MSB.
REQ-016 SHALL run FSM states FILL (fewer than PAT_W bits held) and HUNT (full window), with fill count 0..PAT_W.
REQ-017 SHALL move FILL->HUNT on the valid bit that makes fill = PAT_W.
REQ-018 SHALL, in HUNT, flag a match when the post-shift history equals pat_q.
REQ-019 SHALL raise out for exactly the one cycle after the edge sampling the completing bit; latency is 1 cycle; out is low in all other cycles.
REQ-020 SHALL, in overlapping mode, stay in HUNT after a match, so trailing bits count toward the next match.
REQ-021 SHALL, in non-overlapping mode, clear fill to 0 and return to FILL after a match.
REQ-022 SHALL, with in_valid low, hold history, fill and state, and keep out low.
REQ-023 SHALL, on cfg_load, latch pattern->pat_q and overlap->overlap_q, clear history and fill, and enter FILL.
REQ-024 SHALL give cfg_load priority over in_valid in the same cycle; that bit is discarded, and out is low next cycle.
REQ-025 SHALL increment match_cnt by 1 per match and hold it at all-ones.
REQ-026 SHALL give cnt_clr priority over a coincident match, so match_cnt becomes 0.
REQ-027 SHALL leave history and FSM unaffected by cnt_clr.

Reset
REQ-028 SHALL, on rst_n low, asynchronously set out=0, match_cnt=0, history=0, fill=0, state=FILL, pat_q=RESET_PAT, overlap_q=RESET_OVL.
REQ-029 SHALL discard a match in progress when reset occurs mid-pattern; detection restarts from FILL.

Configuration
REQ-030 SHALL, with SEQDET_CNT_EN defined, include the match_cnt counter and cnt_clr logic.
REQ-031 SHALL, without SEQDET_CNT_EN, drive match_cnt constant 0, ignore cnt_clr, and leave out behaviour unchanged.

Structure
REQ-032 SHALL place the FSM state enum (FILL, HUNT) and the PAT_W/CNT_W legal-range constants in shared package seqdet_pkg.
REQ-033 SHALL implement the saturating counter as sub-module seqdet_sat_cnt (ports clk, rst_n, inc, clr, cnt), instantiated only under SEQDET_CNT_EN.

Verification
REQ-034 SHALL cover: default params, overlap=1, valid stream 1,0,1,0,1 -> out pulses after bits 3 and 5, match_cnt=2.
REQ-035 SHALL cover: cfg_load overlap=0, pattern 101, stream 1,0,1,0,1 -> out pulse after bit 3 only, match_cnt=1.
REQ-036 SHALL cover: stream 1,0 then in_valid low 4 cycles then 1 -> out pulse once, 1 cycle after the final bit, and no pulse during the gap.
REQ-037 SHALL cover: CNT_W=2, 5 matches -> match_cnt reads 1,2,3,3,3; cnt_clr asserted together with match 6 -> 0.
REQ-038 SHALL cover: rst_n low after bits 1,0, then 1 -> no pulse; cfg_load with in_valid=1 same cycle -> bit discarded, FILL, fill=0.
REQ-039 SHALL cover: a build without SEQDET_CNT_EN, repeating REQ-034 -> identical out, match_cnt stays 0.
